// File: rtl/ov7670_cam_emulator.sv
// Synthetic OV7670 camera source: emits RGB565 test frames as a PCLK/HREF/VSYNC byte stream.
// Data is updated on the PCLK falling edge so it is stable where the receiver samples.
module ov7670_cam_emulator #(
  parameter int unsigned H_ACTIVE  = 160,
  parameter int unsigned V_ACTIVE  = 120,
  parameter int unsigned H_BLANK   = 16,
  parameter int unsigned VS_LINES  = 3,
  parameter int unsigned VBP_LINES = 2,
  parameter int unsigned VFP_LINES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [1:0] pattern_sel,
  output logic       CAM_PCLK,
  output logic       CAM_HREF,
  output logic       CAM_VSYNC,
  output logic [7:0] CAM_DATOS,
  output logic       frame_done,
  output logic [7:0] frame_cnt
);

  localparam int unsigned LINE_LEN    = 2 * H_ACTIVE + H_BLANK;
  localparam int unsigned FRAME_LINES = VS_LINES + VBP_LINES + V_ACTIVE + VFP_LINES;
  localparam int unsigned BX_W        = $clog2(LINE_LEN);
  localparam int unsigned LY_W        = $clog2(FRAME_LINES);
  localparam int unsigned V_START     = VS_LINES + VBP_LINES;
  localparam int unsigned BAR_W       = H_ACTIVE / 8;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [0:0]      state_q, state_d;
  logic            pclk_q, pclk_d;
  logic [BX_W-1:0] bx_q, bx_d;
  logic [LY_W-1:0] ly_q, ly_d;
  logic [1:0]      sel_q, sel_d;
  logic            done_q, done_d;
  logic [7:0]      cnt_q, cnt_d;

  logic [31:0] bx32, ly32, px32, py32, bar;
  logic        last_bx, last_line, run, active_line;
  logic [15:0] pixel;

  assign bx32      = 32'(bx_q);
  assign ly32      = 32'(ly_q);
  assign last_bx   = (bx32 == LINE_LEN - 1);
  assign last_line = (ly32 == FRAME_LINES - 1);

  always_comb begin
    state_d = state_q;
    pclk_d  = pclk_q;
    bx_d    = bx_q;
    ly_d    = ly_q;
    sel_d   = sel_q;
    unique case (state_q)
      ST_IDLE: begin
        pclk_d = 1'b0;
        if (en) begin
          state_d = ST_RUN;
          bx_d    = '0;
          ly_d    = '0;
          sel_d   = pattern_sel;
        end
      end
      default: begin
        pclk_d = ~pclk_q;
        if (pclk_q) begin
          if (last_bx && last_line) begin
            bx_d = '0;
            ly_d = '0;
            if (en) sel_d = pattern_sel;
            else    state_d = ST_IDLE;
          end else if (last_bx) begin
            bx_d = '0;
            ly_d = ly_q + 1'b1;
          end else begin
            bx_d = bx_q + 1'b1;
          end
        end
      end
    endcase
    // Pulse on the falling-PCLK edge that puts the frame's final byte on the bus
    done_d = pclk_q && (32'(bx_d) == LINE_LEN - 1) && (32'(ly_d) == FRAME_LINES - 1);
    cnt_d  = cnt_q + 8'(done_d);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      pclk_q  <= 1'b0;
      bx_q    <= '0;
      ly_q    <= '0;
      sel_q   <= 2'd0;
      done_q  <= 1'b0;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      pclk_q  <= pclk_d;
      bx_q    <= bx_d;
      ly_q    <= ly_d;
      sel_q   <= sel_d;
      done_q  <= done_d;
      cnt_q   <= cnt_d;
    end
  end

  assign run         = (state_q == ST_RUN);
  assign active_line = (ly32 >= V_START) && (ly32 < V_START + V_ACTIVE);
  assign px32        = bx32 >> 1;
  assign py32        = ly32 - V_START;
  assign bar         = px32 / BAR_W;

  always_comb begin
    pixel = 16'h0000;
    unique case (sel_q)
      2'd0: begin
        unique case (bar)
          32'd0:   pixel = 16'hFFFF;
          32'd1:   pixel = 16'hFFE0;
          32'd2:   pixel = 16'h07FF;
          32'd3:   pixel = 16'h07E0;
          32'd4:   pixel = 16'hF81F;
          32'd5:   pixel = 16'hF800;
          32'd6:   pixel = 16'h001F;
          default: pixel = 16'h0000;
        endcase
      end
      2'd1:    pixel = {px32[4:0], py32[5:0], cnt_q[4:0]};
      2'd2:    pixel = 16'(py32 * H_ACTIVE + px32);
      default: pixel = 16'h0000;
    endcase
  end

  assign CAM_PCLK   = pclk_q;
  assign CAM_VSYNC  = run && (ly32 < VS_LINES);
  assign CAM_HREF   = run && active_line && (bx32 < 2 * H_ACTIVE);
  assign CAM_DATOS  = CAM_HREF ? (bx_q[0] ? pixel[7:0] : pixel[15:8]) : 8'h00;
  assign frame_done = done_q;
  assign frame_cnt  = cnt_q;

endmodule

// File: tb/tb_ov7670_cam_emulator.sv
// Randomized bench for ov7670_cam_emulator against a time-indexed frame model.
// A reduced geometry keeps several full frames short.
module tb_ov7670_cam_emulator;

  localparam int H_ACTIVE  = 16;
  localparam int V_ACTIVE  = 5;
  localparam int H_BLANK   = 6;
  localparam int VS_LINES  = 2;
  localparam int VBP_LINES = 1;
  localparam int VFP_LINES = 2;
  localparam int LINE_LEN  = 2 * H_ACTIVE + H_BLANK;
  localparam int FLINES    = VS_LINES + VBP_LINES + V_ACTIVE + VFP_LINES;
  localparam int FBYTES    = LINE_LEN * FLINES;
  localparam int FRAME_CLK = 2 * FBYTES;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en = 1'b0;
  logic [1:0] sel = 2'd0;
  logic       cam_pclk, cam_href, cam_vsync, frame_done;
  logic [7:0] cam_datos, frame_cnt;
  logic [19:0] obs, exp_v;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  // Model state: running flag, clk periods since the frame's entry edge, latched pattern, frames done
  bit m_run = 1'b0;
  int m_t   = 0;
  int m_sel = 0;
  int m_cnt = 0;

  ov7670_cam_emulator #(
    .H_ACTIVE (H_ACTIVE),
    .V_ACTIVE (V_ACTIVE),
    .H_BLANK  (H_BLANK),
    .VS_LINES (VS_LINES),
    .VBP_LINES(VBP_LINES),
    .VFP_LINES(VFP_LINES)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .pattern_sel(sel),
    .CAM_PCLK   (cam_pclk),
    .CAM_HREF   (cam_href),
    .CAM_VSYNC  (cam_vsync),
    .CAM_DATOS  (cam_datos),
    .frame_done (frame_done),
    .frame_cnt  (frame_cnt)
  );

  always #5 clk = ~clk;

  assign obs = {cam_pclk, cam_href, cam_vsync, cam_datos, frame_done, frame_cnt};

  function automatic logic [15:0] ref_pixel(int s, int cnt, int px, int py);
    logic [15:0] bars [8];
    bars = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0, 16'hF81F, 16'hF800, 16'h001F, 16'h0000};
    case (s)
      0:       return bars[px / (H_ACTIVE / 8)];
      1:       return 16'(((px % 32) << 11) | ((py % 64) << 5) | (cnt % 32));
      2:       return 16'((py * H_ACTIVE + px) % 65536);
      default: return 16'h0000;
    endcase
  endfunction

  function automatic logic [19:0] ref_vec();
    int k, line, bx;
    logic href, vs, done;
    logic [7:0] d;
    logic [15:0] p;
    logic [7:0] c;
    c = 8'(m_cnt);
    if (!m_run) return {12'h000, c};
    k    = m_t / 2;
    line = k / LINE_LEN;
    bx   = k % LINE_LEN;
    vs   = line < VS_LINES;
    href = (line >= VS_LINES + VBP_LINES) && (line < VS_LINES + VBP_LINES + V_ACTIVE) &&
           (bx < 2 * H_ACTIVE);
    d    = 8'h00;
    if (href) begin
      p = ref_pixel(m_sel, m_cnt, bx / 2, line - VS_LINES - VBP_LINES);
      d = (bx % 2 == 1) ? p[7:0] : p[15:8];
    end
    done = (m_t == 2 * (FBYTES - 1));
    return {(m_t % 2 == 1), href, vs, d, done, c};
  endfunction

  function automatic string fmt(logic [19:0] v);
    return $sformatf("pclk=%b href=%b vsync=%b data=%02h done=%b cnt=%0d",
                     v[19], v[18], v[17], v[16:9], v[8], v[7:0]);
  endfunction

  task automatic model_edge();
    if (!rst) begin
      m_run = 1'b0; m_t = 0; m_cnt = 0;
    end else if (!m_run) begin
      if (en) begin m_run = 1'b1; m_t = 0; m_sel = int'(sel); end
    end else if (m_t == FRAME_CLK - 1) begin
      if (en) begin m_t = 0; m_sel = int'(sel); end
      else m_run = 1'b0;
    end else begin
      m_t++;
      if (m_t == 2 * (FBYTES - 1)) m_cnt = (m_cnt + 1) % 256;
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      en = 1'($urandom); sel = 2'($urandom);
      cycle();
      vectors++;
      if (obs !== 20'h0) begin
        miscompares++;
        $display("FAIL reset got %s want all zero", fmt(obs));
      end
    end
    rst = 1'b1; en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      sel = 2'($urandom);
      cycle();
      exp_v = ref_vec();
      vectors++;
      if (obs !== exp_v) begin
        miscompares++;
        $display("FAIL reset_release got %s want %s", fmt(obs), fmt(exp_v));
      end
    end
  endtask

  // Four back-to-back frames, one per pattern; en and sel jitter mid-frame and must be ignored
  task automatic test_patterns();
    logic [1:0] plan [4];
    int fi, last_done, pulses;
    plan = '{2'd2, 2'd0, 2'd1, 2'd3};
    fi = 0; last_done = -1; pulses = 0;
    for (int c = 0; c < 4 * FRAME_CLK; c++) begin
      if (!m_run || m_t == FRAME_CLK - 1) begin
        en = 1'b1; sel = plan[fi % 4]; fi++;
      end else begin
        en = 1'($urandom); sel = 2'($urandom);
      end
      cycle();
      exp_v = ref_vec();
      vectors++;
      if (obs !== exp_v) begin
        miscompares++;
        $display("FAIL patterns c=%0d sel=%0d got %s want %s", c, m_sel, fmt(obs), fmt(exp_v));
      end
      if (frame_done === 1'b1) begin
        pulses++;
        if (last_done >= 0) begin
          vectors++;
          if (c - last_done != FRAME_CLK) begin
            miscompares++;
            $display("FAIL done_period got %0d want %0d", c - last_done, FRAME_CLK);
          end
        end
        last_done = c;
      end
    end
    vectors++;
    if (pulses != 4) begin
      miscompares++;
      $display("FAIL done_pulses got %0d want 4", pulses);
    end
  endtask

  // en drops mid-frame: frame completes, one pulse, then PCLK parks low
  task automatic test_en_drop();
    int pulses, start_cnt, c;
    start_cnt = m_cnt; pulses = 0; c = 0;
    en = 1'b1; sel = 2'($urandom);
    cycle();
    while (m_run && c < 2 * FRAME_CLK) begin
      exp_v = ref_vec();
      vectors++;
      if (obs !== exp_v) begin
        miscompares++;
        $display("FAIL en_drop c=%0d got %s want %s", c, fmt(obs), fmt(exp_v));
      end
      if (frame_done === 1'b1) pulses++;
      en  = (m_t < 2 * 4 * LINE_LEN) ? 1'b1 : 1'b0;
      sel = 2'($urandom);
      cycle();
      c++;
    end
    vectors++;
    if (pulses != 1 || frame_cnt !== 8'(start_cnt + 1)) begin
      miscompares++;
      $display("FAIL en_drop_end got pulses=%0d cnt=%0d want pulses=1 cnt=%0d",
               pulses, frame_cnt, start_cnt + 1);
    end
    for (int i = 0; i < 200; i++) begin
      sel = 2'($urandom);
      cycle();
      exp_v = ref_vec();
      vectors++;
      if (obs !== exp_v) begin
        miscompares++;
        $display("FAIL idle i=%0d got %s want %s", i, fmt(obs), fmt(exp_v));
      end
    end
  endtask

  // Asynchronous reset mid-line, then restart from a fresh frame
  task automatic test_async_reset();
    en = 1'b1; sel = 2'd2;
    cycle();
    for (int i = 0; i < 2 * ((VS_LINES + VBP_LINES + 2) * LINE_LEN + 7); i++) begin
      cycle();
      exp_v = ref_vec();
      vectors++;
      if (obs !== exp_v) begin
        miscompares++;
        $display("FAIL pre_reset i=%0d got %s want %s", i, fmt(obs), fmt(exp_v));
      end
    end
    #2 rst = 1'b0;
    #1;
    m_run = 1'b0; m_t = 0; m_cnt = 0;
    vectors++;
    if (obs !== 20'h0) begin
      miscompares++;
      $display("FAIL async_reset got %s want all zero", fmt(obs));
    end
    for (int i = 0; i < 3; i++) cycle();
    rst = 1'b1; en = 1'b1; sel = 2'($urandom);
    cycle();
    vectors++;
    if (cam_vsync !== 1'b1 || frame_cnt !== 8'd0) begin
      miscompares++;
      $display("FAIL restart got vsync=%b cnt=%0d want vsync=1 cnt=0", cam_vsync, frame_cnt);
    end
    for (int i = 0; i < 2 * (VS_LINES + 2) * LINE_LEN; i++) begin
      en = 1'($urandom); sel = 2'($urandom);
      cycle();
      exp_v = ref_vec();
      vectors++;
      if (obs !== exp_v) begin
        miscompares++;
        $display("FAIL restart_run i=%0d got %s want %s", i, fmt(obs), fmt(exp_v));
      end
    end
  endtask

  initial begin
    test_reset();
    test_patterns();
    test_en_drop();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
